mxv_hex_word_ctrl: RTL

- Sequencer in front of the ascii2hex decoder on the UART receive path of the mxv design.
- Takes one received ASCII byte per rx_valid pulse and classifies it as hex digit, separator ('_', 0x5F) or invalid.
- Packs consecutive digits MSB-first into a word and presents each completed word to the mxv loader on a valid/ready handshake.
- Reports framing errors as one-cycle pulses with a code.

---
 rtl/mxv_pkg.sv | 10 +
 rtl/ascii2hex.sv | 12 +
 rtl/mxv_hex_word_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/mxv_pkg.sv
// mxv_pkg: shared UART/hex types and constants for the mxv receive path
package mxv_pkg;
  typedef logic [7:0] data_uart_t;
  typedef logic [4:0] data_hex_t;
  localparam data_uart_t KEY_0 = 8'h30;
  localparam data_uart_t KEY_SEP = 8'h5F;
  localparam data_hex_t HEX_SEP = 5'd30;
  typedef enum logic [1:0] {ERR_NONE, ERR_BADCHAR, ERR_OVFL, ERR_OVERRUN} err_code_t;
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD, DISCARD} ctrl_state_t;
endpackage

// File: rtl/ascii2hex.sv
// ascii2hex: maps '0'-'9','A'-'F' to 0-15, '_' to HEX_SEP, anything else to 0
module ascii2hex
  import mxv_pkg::*;
(
  input  data_uart_t ascii,
  output data_hex_t  hex
);
  always_comb
    hex = (ascii >= 8'h30 && ascii <= 8'h39) ? data_hex_t'(ascii - 8'h30) :
          (ascii >= 8'h41 && ascii <= 8'h46) ? data_hex_t'(ascii - 8'h37) :
          (ascii == KEY_SEP)                 ? HEX_SEP : '0;
endmodule

// File: rtl/mxv_hex_word_ctrl.sv
// mxv_hex_word_ctrl: packs received hex digits into words and hands them to the loader
module mxv_hex_word_ctrl
  import mxv_pkg::*;
#(
  parameter int MAX_DIGITS = 2,
  parameter int CNT_W = 16,
  localparam int WORD_W = 4 * MAX_DIGITS
) (
  input  logic              clk,
  input  logic              rst,
  input  data_uart_t        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [WORD_W-1:0] word_data,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              err,
  output err_code_t         err_code,
  output logic [CNT_W-1:0]  word_cnt
);
  data_hex_t h;
  ctrl_state_t state_q, state_d;
  logic [WORD_W-1:0] acc_q, acc_d, acc_sh, word_data_q, word_data_d;
  logic [3:0] cnt_q, cnt_d;
  logic word_valid_q, word_valid_d, err_q, err_d, is_dig, is_sep, hs;
  err_code_t err_code_q, err_code_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;

  ascii2hex u_a2h (.ascii(rx_data), .hex(h));

  // invalid characters decode to 0, so a real '0' is told apart by its ASCII code
  assign is_dig = h <= 5'd15 && (h != 5'd0 || rx_data == KEY_0);
  assign is_sep = h == HEX_SEP;
  assign acc_sh = (acc_q << 4) | WORD_W'(h[3:0]);
  assign hs = word_valid_q && word_ready;

  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    word_data_d = word_data_q;
    word_valid_d = word_valid_q;
    word_cnt_d = word_cnt_q;
    err_code_d = ERR_NONE;
    case (state_q)
      IDLE:
        if (rx_valid && is_dig) begin
          acc_d = WORD_W'(h[3:0]);
          cnt_d = 4'd1;
          state_d = ACCUM;
        end else if (rx_valid && !is_sep) err_code_d = ERR_BADCHAR;
      ACCUM:
        if (rx_valid && is_dig && cnt_q < 4'(MAX_DIGITS)) begin
          acc_d = acc_sh;
          cnt_d = cnt_q + 4'd1;
        end else if (rx_valid && is_sep) begin
          word_data_d = acc_q;
          word_valid_d = 1'b1;
          state_d = HOLD;
        end else if (rx_valid) begin
          err_code_d = is_dig ? ERR_OVFL : ERR_BADCHAR;
          state_d = DISCARD;
        end
      HOLD: begin
        err_code_d = rx_valid ? ERR_OVERRUN : ERR_NONE;
        if (hs) begin
          word_valid_d = 1'b0;
          word_cnt_d = &word_cnt_q ? word_cnt_q : word_cnt_q + 1'b1;
          acc_d = '0;
          cnt_d = 4'd0;
          state_d = IDLE;
        end
      end
      DISCARD:
        if (rx_valid && is_sep) begin
          acc_d = '0;
          cnt_d = 4'd0;
          state_d = IDLE;
        end
    endcase
    err_d = err_code_d != ERR_NONE;
  end

  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      acc_q <= '0;
      cnt_q <= 4'd0;
      word_data_q <= '0;
      word_valid_q <= 1'b0;
      err_q <= 1'b0;
      err_code_q <= ERR_NONE;
      word_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      word_data_q <= word_data_d;
      word_valid_q <= word_valid_d;
      err_q <= err_d;
      err_code_q <= err_code_d;
      word_cnt_q <= word_cnt_d;
    end

  assign rx_ready = state_q != HOLD;
  assign word_data = word_data_q;
  assign word_valid = word_valid_q;
  assign err = err_q;
  assign err_code = err_code_q;
  assign word_cnt = word_cnt_q;
endmodule
